// File: rtl/outerprod_uc.sv
// outerprod_uc: unary-computing outer-product (rank-1 update) array.
//   ROWNUM x COLNUM cells. Each cell ANDs a row bitstream with a column bitstream
//   and accumulates a signed, saturating count of coincident ones. Accumulators
//   persist across runs, so successive runs add further rank-1 updates.
// Ports:
//   iClk, iRstN      clock, async active-low reset
//   iEn              run enable (low stalls counter and accumulation)
//   iClr             sync clear of accumulators; aborts any run
//   iStart, iMode    run request (IDLE only); 0 = rate-coded P cycles, 1 = exact P^2 cycles
//   iData0 / iData1  sign-magnitude row / column vectors, latched at start
//   oData            cell (i,j) at [(i*COLNUM+j)*OUTBITWIDTH +: OUTBITWIDTH], two's complement
//   oBusy, oDone     high while running / one-cycle pulse once the run completes

module outerprod_uc_cell #(
    parameter int OUTBITWIDTH = 8
) (
    input  logic                   iClk,
    input  logic                   iRstN,
    input  logic                   iClr,
    input  logic                   iStep,
    input  logic                   iHit,
    input  logic                   iNeg,
    output logic [OUTBITWIDTH-1:0] oAcc
);
    localparam logic [OUTBITWIDTH-1:0] ACCMAX = {1'b0, {(OUTBITWIDTH-1){1'b1}}};
    localparam logic [OUTBITWIDTH-1:0] ACCMIN = {1'b1, {(OUTBITWIDTH-1){1'b0}}};
    localparam logic [OUTBITWIDTH-1:0] ACCONE = {{(OUTBITWIDTH-1){1'b0}}, 1'b1};

    // Saturating counter: hold at the rails instead of wrapping.
    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            oAcc <= '0;
        end else if (iClr) begin
            oAcc <= '0;
        end else if (iStep && iHit) begin
            if (!iNeg) begin
                if (oAcc != ACCMAX) oAcc <= oAcc + ACCONE;
            end else if (oAcc != ACCMIN) begin
                oAcc <= oAcc - ACCONE;
            end
        end
    end
endmodule

module outerprod_uc #(
    parameter int ROWNUM      = 2,
    parameter int COLNUM      = 2,
    parameter int BITWIDTH    = 4,
    parameter int OUTBITWIDTH = 8
) (
    input  logic                                 iClk,
    input  logic                                 iRstN,
    input  logic                                 iEn,
    input  logic                                 iClr,
    input  logic                                 iStart,
    input  logic                                 iMode,
    input  logic [ROWNUM*BITWIDTH-1:0]           iData0,
    input  logic [COLNUM*BITWIDTH-1:0]           iData1,
    output logic [ROWNUM*COLNUM*OUTBITWIDTH-1:0] oData,
    output logic                                 oBusy,
    output logic                                 oDone
);
    localparam int M = BITWIDTH - 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    typedef struct packed {
        logic                             mode;
        logic [ROWNUM-1:0][BITWIDTH-1:0]  row;
        logic [COLNUM-1:0][BITWIDTH-1:0]  col;
    } opReq_t;

    localparam logic [2*M-1:0] CNTONE  = {{(2*M-1){1'b0}}, 1'b1};
    localparam logic [2*M-1:0] LASTRATE = {{M{1'b0}}, {M{1'b1}}};

    state_t         state;
    logic [2*M-1:0] cnt;
    opReq_t         opQ;
    logic [2*M-1:0] lastCnt;
    logic           step;

    assign lastCnt = opQ.mode ? {(2*M){1'b1}} : LASTRATE;
    assign step    = (state == RUN) && iEn;

    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            state <= IDLE;
            cnt   <= '0;
            opQ   <= '0;
            oBusy <= 1'b0;
            oDone <= 1'b0;
        end else if (iClr) begin
            state <= IDLE;
            cnt   <= '0;
            oBusy <= 1'b0;
            oDone <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    oDone <= 1'b0;
                    if (iStart) begin
                        opQ   <= {iMode, iData0, iData1};
                        cnt   <= '0;
                        oBusy <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (iEn) begin
                        cnt <= cnt + CNTONE;
                        if (cnt == lastCnt) begin
                            oBusy <= 1'b0;
                            oDone <= 1'b1;
                            state <= DONE;
                        end
                    end
                end
                DONE: begin
                    oDone <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Rate mode decorrelates the column stream with a bit-reversed count;
    // temporal mode sweeps the column threshold once per full row sweep,
    // giving exactly mag0*mag1 coincidences.
    logic [M-1:0] cntLo, cntHi, cntRev, colRef;
    assign cntLo = cnt[M-1:0];
    assign cntHi = cnt[2*M-1:M];

    always_comb begin
        cntRev = '0;
        for (int b = 0; b < M; b++) cntRev[b] = cntLo[M-1-b];
    end

    assign colRef = opQ.mode ? cntHi : cntRev;

    logic [ROWNUM-1:0] rowBit;
    logic [COLNUM-1:0] colBit;

    genvar i, j;
    generate
        for (i = 0; i < ROWNUM; i++) begin : gRow
            assign rowBit[i] = opQ.row[i][M-1:0] > cntLo;
        end
        for (j = 0; j < COLNUM; j++) begin : gCol
            assign colBit[j] = opQ.col[j][M-1:0] > colRef;
        end
        for (i = 0; i < ROWNUM; i++) begin : gCellRow
            for (j = 0; j < COLNUM; j++) begin : gCellCol
                // A zero magnitude never produces a one, so -0 never contributes.
                outerprod_uc_cell #(.OUTBITWIDTH(OUTBITWIDTH)) uCell (
                    .iClk  (iClk),
                    .iRstN (iRstN),
                    .iClr  (iClr),
                    .iStep (step),
                    .iHit  (rowBit[i] & colBit[j]),
                    .iNeg  (opQ.row[i][M] ^ opQ.col[j][M]),
                    .oAcc  (oData[(i*COLNUM+j)*OUTBITWIDTH +: OUTBITWIDTH])
                );
            end
        end
    endgenerate
endmodule

// File: tb/tb_outerprod_uc.sv
// Bench for outerprod_uc: two instances (8-bit and 5-bit accumulators) share
// stimulus; a spec-level model predicts every output each cycle, and directed
// runs pin hand-computed results.
module tb_outerprod_uc;
    localparam int NC = 4;

    logic        iClk = 1'b0;
    logic        iRstN, iEn, iClr, iStart, iMode;
    logic [7:0]  iData0, iData1;
    logic [31:0] oDataA;
    logic [19:0] oDataB;
    logic        oBusyA, oDoneA, oBusyB, oDoneB;

    int checks = 0;
    int errors = 0;

    always #5 iClk = ~iClk;

    outerprod_uc #(.ROWNUM(2), .COLNUM(2), .BITWIDTH(4), .OUTBITWIDTH(8)) dutA (
        .iClk(iClk), .iRstN(iRstN), .iEn(iEn), .iClr(iClr), .iStart(iStart), .iMode(iMode),
        .iData0(iData0), .iData1(iData1), .oData(oDataA), .oBusy(oBusyA), .oDone(oDoneA));

    outerprod_uc #(.ROWNUM(2), .COLNUM(2), .BITWIDTH(4), .OUTBITWIDTH(5)) dutB (
        .iClk(iClk), .iRstN(iRstN), .iEn(iEn), .iClr(iClr), .iStart(iStart), .iMode(iMode),
        .iData0(iData0), .iData1(iData1), .oData(oDataB), .oBusy(oBusyB), .oDone(oDoneB));

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
        end
    endtask

    function automatic int cellA(input int c);
        logic signed [7:0] t;
        t = oDataA[c*8 +: 8];
        return int'(t);
    endfunction

    function automatic int cellB(input int c);
        logic signed [4:0] t;
        t = oDataB[c*5 +: 5];
        return int'(t);
    endfunction

    function automatic logic [3:0] sm(input bit s, input int m);
        logic [2:0] mg;
        mg = m[2:0];
        return {s, mg};
    endfunction

    // ---------------- model ----------------
    int mPhase, mK, mLen, mMode;   // mPhase: 0 idle, 1 running, 2 done
    int mMag0[2], mMag1[2];
    bit mSg0[2], mSg1[2];
    int mBase[2][NC];
    int wOf[2] = '{8, 5};

    function automatic int bitrev3(input int v);
        int r = 0;
        for (int b = 0; b < 3; b++) if (v[b]) r = r | (1 << (2 - b));
        return r;
    endfunction

    // Coincident ones over the first k stream positions.
    function automatic int hits(input int m0, input int m1, input int mode, input int k);
        int n = 0;
        for (int t = 0; t < k; t++) begin
            int lo = t % 8;
            int hi = t / 8;
            bit rb = m0 > lo;
            bit cb = mode ? (m1 > hi) : (m1 > bitrev3(lo));
            if (rb && cb) n++;
        end
        return n;
    endfunction

    function automatic int clampW(input int v, input int w);
        int mx = (1 << (w - 1)) - 1;
        int mn = -(1 << (w - 1));
        return (v > mx) ? mx : ((v < mn) ? mn : v);
    endfunction

    function automatic int expCell(input int w, input int c);
        int i = c / 2;
        int j = c % 2;
        int n = hits(mMag0[i], mMag1[j], mMode, mK);
        int s = (mSg0[i] != mSg1[j]) ? -1 : 1;
        return clampW(mBase[w][c] + s * n, wOf[w]);
    endfunction

    always @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            mPhase = 0; mK = 0; mLen = 0; mMode = 0;
            for (int i = 0; i < 2; i++) begin
                mMag0[i] = 0; mMag1[i] = 0; mSg0[i] = 0; mSg1[i] = 0;
            end
            for (int w = 0; w < 2; w++) for (int c = 0; c < NC; c++) mBase[w][c] = 0;
        end else if (iClr) begin
            mPhase = 0; mK = 0;
            for (int w = 0; w < 2; w++) for (int c = 0; c < NC; c++) mBase[w][c] = 0;
        end else begin
            case (mPhase)
                0: if (iStart) begin
                    for (int i = 0; i < 2; i++) begin
                        mMag0[i] = int'(iData0[i*4 +: 3]);
                        mMag1[i] = int'(iData1[i*4 +: 3]);
                        mSg0[i]  = iData0[i*4 + 3];
                        mSg1[i]  = iData1[i*4 + 3];
                    end
                    mMode  = iMode ? 1 : 0;
                    mLen   = iMode ? 64 : 8;
                    mK     = 0;
                    mPhase = 1;
                end
                1: if (iEn) begin
                    mK++;
                    if (mK == mLen) begin
                        for (int w = 0; w < 2; w++)
                            for (int c = 0; c < NC; c++) mBase[w][c] = expCell(w, c);
                        mK = 0;
                        mPhase = 2;
                    end
                end
                default: mPhase = 0;
            endcase
        end
    end

    // Per-cycle compare against the model.
    always @(negedge iClk) begin
        chk("busyA", int'(oBusyA), int'(mPhase == 1));
        chk("doneA", int'(oDoneA), int'(mPhase == 2));
        chk("busyB", int'(oBusyB), int'(mPhase == 1));
        chk("doneB", int'(oDoneB), int'(mPhase == 2));
        for (int c = 0; c < NC; c++) begin
            chk($sformatf("cellA%0d", c), cellA(c), expCell(0, c));
            chk($sformatf("cellB%0d", c), cellB(c), expCell(1, c));
        end
    end

    // ---------------- stimulus ----------------
    task automatic clr();
        iClr = 1'b1;
        @(posedge iClk); #2;
        iClr = 1'b0;
    endtask

    task automatic doRun(input logic [7:0] d0, input logic [7:0] d1, input logic mode,
                         input bit toggle, input bit midStart, output int busy);
        iData0 = d0; iData1 = d1; iMode = mode; iEn = 1'b1; iStart = 1'b1;
        @(posedge iClk); #2;
        iStart = 1'b0;
        busy = 0;
        for (int n = 0; n < 5000; n++) begin
            if (oDoneA) break;
            if (oBusyA) busy++;
            @(posedge iClk); #2;
            if (toggle) iEn = ~iEn;
            if (midStart) iStart = (n == 10);
        end
        chk("doneSeen", int'(oDoneA), 1);
        iStart = 1'b0; iEn = 1'b1;
        @(posedge iClk); #2;
    endtask

    initial begin
        int b;
        iRstN = 1'b0; iEn = 1'b0; iClr = 1'b0; iStart = 1'b0; iMode = 1'b0;
        iData0 = '0; iData1 = '0;
        repeat (3) @(posedge iClk);
        #2;
        chk("rstCellA0", cellA(0), 0);
        chk("rstBusy", int'(oBusyA), 0);
        iRstN = 1'b1;
        @(posedge iClk); #2;

        // Mode 0: (+2) x (-4) -> -1 after 8 cycles
        doRun({sm(0,0), sm(0,2)}, {sm(0,0), sm(1,4)}, 1'b0, 0, 0, b);
        chk("t1Busy", b, 8);
        chk("t1Cell00", cellA(0), -1);
        chk("t1Model", expCell(0, 0), -1);

        // Mode 0 and mode 1 of (-6) x (+4)
        clr();
        doRun({sm(0,0), sm(1,6)}, {sm(0,0), sm(0,4)}, 1'b0, 0, 0, b);
        chk("t2Busy", b, 8);
        chk("t2Cell00", cellA(0), -3);
        clr();
        doRun({sm(0,5), sm(1,6)}, {sm(1,2), sm(0,4)}, 1'b1, 0, 0, b);
        chk("t3Busy", b, 64);
        chk("t3Cell00", cellA(0), -24);
        chk("t3Cell01", cellA(1), 12);
        chk("t3Cell10", cellA(2), 20);
        chk("t3Cell11", cellA(3), -10);
        chk("t3SatB00", cellB(0), -16);
        chk("t3SatB10", cellB(2), 15);

        // Accumulate across runs, with a stray iStart mid-run
        clr();
        doRun({sm(0,0), sm(0,3)}, {sm(0,0), sm(0,5)}, 1'b1, 0, 1, b);
        chk("t4Busy", b, 64);
        chk("t4Cell00", cellA(0), 15);
        doRun({sm(0,0), sm(0,3)}, {sm(0,0), sm(0,5)}, 1'b1, 0, 0, b);
        chk("t4AccA", cellA(0), 30);
        chk("t4AccB", cellB(0), 15);
        chk("t4Model", expCell(0, 0), 30);

        // 50% enable: same result, stretched busy
        clr();
        doRun({sm(0,0), sm(1,6)}, {sm(0,0), sm(0,4)}, 1'b0, 1, 0, b);
        chk("t5Busy", b, 15);
        chk("t5Cell00", cellA(0), -3);

        // Saturation on the 5-bit instance
        clr();
        doRun({sm(0,0), sm(1,7)}, {sm(0,0), sm(0,7)}, 1'b1, 0, 0, b);
        chk("t6NegA", cellA(0), -49);
        chk("t6NegB", cellB(0), -16);
        clr();
        doRun({sm(0,0), sm(0,7)}, {sm(0,0), sm(0,7)}, 1'b1, 0, 0, b);
        chk("t6PosA", cellA(0), 49);
        chk("t6PosB", cellB(0), 15);

        // Clear mid-run together with iStart
        clr();
        iData0 = {sm(0,0), sm(0,3)}; iData1 = {sm(0,0), sm(0,5)}; iMode = 1'b1; iStart = 1'b1;
        @(posedge iClk); #2;
        iStart = 1'b0;
        repeat (20) @(posedge iClk);
        #2;
        chk("t7Partial", int'(cellA(0) != 0), 1);
        iClr = 1'b1; iStart = 1'b1;
        @(posedge iClk); #2;
        iClr = 1'b0; iStart = 1'b0;
        chk("t7Cell00", cellA(0), 0);
        chk("t7Busy", int'(oBusyA), 0);
        chk("t7Done", int'(oDoneA), 0);
        repeat (70) @(posedge iClk);
        #2;
        chk("t7StillIdle", int'(oBusyA), 0);

        // Reset mid-run: outputs clear immediately
        iData0 = {sm(0,4), sm(0,7)}; iData1 = {sm(1,3), sm(0,7)}; iMode = 1'b1; iStart = 1'b1;
        @(posedge iClk); #2;
        iStart = 1'b0;
        repeat (12) @(posedge iClk);
        #2;
        iRstN = 1'b0;
        #1;
        chk("t8Data", int'(oDataA != '0), 0);
        chk("t8Busy", int'(oBusyA), 0);
        chk("t8Done", int'(oDoneA), 0);
        @(posedge iClk); #2;
        iRstN = 1'b1;
        repeat (3) @(posedge iClk);
        #2;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
